// File: rtl/sram_responder.sv
// ============================================================================
// Module   : sram_responder
// Brief    : Block-RAM stand-in for the dual-chip 16-bit async SRAM bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] ram_addr,
    input  logic [31:0] ram_data_in,
    output logic [31:0] ram_data_out,
    output logic [3:0]  ram_data_oe,
    input  logic [1:0]  ram_ce_n,
    input  logic [1:0]  ram_ub_n,
    input  logic [1:0]  ram_lb_n,
    input  logic [1:0]  ram_we_n,
    input  logic [1:0]  ram_oe_n,
    output logic        err_contention,
    output logic [15:0] access_count
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] c_LAT_M1   = 3'(READ_LAT - 1);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_WAIT  = 2'd1;
    localparam logic [1:0] S_RD_DRIVE = 2'd2;
    localparam logic [1:0] S_WR       = 2'd3;

    logic [17:0] r_addr;
    logic [31:0] r_din;
    logic [1:0]  r_ce_n, r_ub_n, r_lb_n, r_we_n, r_oe_n;
    logic        r_err;
    logic [15:0] r_count;

    logic [1:0][15:0] w_dout;
    logic [1:0][1:0]  w_oe;
    logic [1:0]       w_done;
    logic [1:0]       w_cont;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_din  <= '0;
            r_ce_n <= 2'b11;
            r_ub_n <= 2'b11;
            r_lb_n <= 2'b11;
            r_we_n <= 2'b11;
            r_oe_n <= 2'b11;
        end else begin
            r_addr <= ram_addr;
            r_din  <= ram_data_in;
            r_ce_n <= ram_ce_n;
            r_ub_n <= ram_ub_n;
            r_lb_n <= ram_lb_n;
            r_we_n <= ram_we_n;
            r_oe_n <= ram_oe_n;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_chip
        logic [1:0]        r_state, w_state_nxt;
        logic [2:0]        r_lat, w_lat_nxt;
        logic [17:0]       r_rd_addr;
        logic [ADDR_W-1:0] r_wr_addr;
        logic [15:0]       r_wr_data;
        logic [1:0]        r_wr_lanes;
        logic [1:0]        r_lanes;
        logic [15:0]       r_rd_word;
        logic [15:0]       r_mem [c_DEPTH];
        logic              w_wr, w_rd, w_addr_chg, w_commit, w_fin, w_rd_load;
        logic [1:0]        w_lane_req;
        logic [15:0]       w_dout_chip;

        assign w_wr       = ~r_ce_n[gi] & ~r_we_n[gi];
        assign w_rd       = ~r_ce_n[gi] & ~r_oe_n[gi] & r_we_n[gi];
        assign w_addr_chg = (r_addr != r_rd_addr);
        assign w_lane_req = {~r_ub_n[gi], ~r_lb_n[gi]};
        assign w_rd_load  = (w_state_nxt == S_RD_DRIVE) && (r_state != S_RD_DRIVE);

        // The exit from RD_WAIT happens on the edge that takes the count to zero.
        always_comb begin
            w_state_nxt = r_state;
            w_lat_nxt   = r_lat;
            w_commit    = 1'b0;
            w_fin       = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        w_state_nxt = S_WR;
                    end else if (w_rd) begin
                        if (READ_LAT == 1) begin
                            w_state_nxt = S_RD_DRIVE;
                        end else begin
                            w_state_nxt = S_RD_WAIT;
                            w_lat_nxt   = c_LAT_M1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (w_wr) begin
                        w_state_nxt = S_WR;
                    end else if (!w_rd) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_addr_chg) begin
                        w_lat_nxt = c_LAT_M1;
                    end else if (r_lat <= 3'd1) begin
                        w_state_nxt = S_RD_DRIVE;
                        w_lat_nxt   = 3'd0;
                    end else begin
                        w_lat_nxt = r_lat - 3'd1;
                    end
                end
                S_RD_DRIVE: begin
                    if (w_wr) begin
                        w_state_nxt = S_WR;
                    end else if (!w_rd) begin
                        w_state_nxt = S_IDLE;
                        w_fin       = 1'b1;
                    end else if (w_addr_chg) begin
                        w_state_nxt = S_RD_WAIT;
                        w_lat_nxt   = c_LAT_M1;
                    end
                end
                S_WR: begin
                    if (!w_wr) begin
                        w_state_nxt = S_IDLE;
                        w_commit    = 1'b1;
                        w_fin       = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state    <= S_IDLE;
                r_lat      <= '0;
                r_rd_addr  <= '0;
                r_wr_addr  <= '0;
                r_wr_data  <= '0;
                r_wr_lanes <= '0;
                r_lanes    <= '0;
                r_rd_word  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_lat   <= w_lat_nxt;
                r_lanes <= (w_state_nxt == S_RD_DRIVE) ? w_lane_req : 2'b00;
                if (w_state_nxt == S_RD_WAIT || w_state_nxt == S_RD_DRIVE) begin
                    r_rd_addr <= r_addr;
                end
                if (w_rd_load) begin
                    r_rd_word <= r_mem[r_addr[ADDR_W-1:0]];
                end
                if (w_wr) begin
                    r_wr_addr  <= r_addr[ADDR_W-1:0];
                    r_wr_data  <= r_din[16*gi +: 16];
                    r_wr_lanes <= w_lane_req;
                end
            end
        end

        // Reset on the completion edge discards the pending write.
        always_ff @(posedge clk) begin
            if (w_commit && !reset) begin
                if (r_wr_lanes[0]) r_mem[r_wr_addr][7:0]  <= r_wr_data[7:0];
                if (r_wr_lanes[1]) r_mem[r_wr_addr][15:8] <= r_wr_data[15:8];
            end
        end

        always_comb begin
            w_dout_chip = r_rd_word & {{8{r_lanes[1]}}, {8{r_lanes[0]}}};
        end

        assign w_dout[gi] = w_dout_chip;
        assign w_oe[gi]   = r_lanes;
        assign w_done[gi] = w_fin;
        assign w_cont[gi] = w_wr & ~r_oe_n[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_err   <= r_err | (|w_cont);
            r_count <= r_count + {15'd0, w_done[0]} + {15'd0, w_done[1]};
        end
    end

    assign ram_data_out   = {w_dout[1], w_dout[0]};
    assign ram_data_oe    = {w_oe[1], w_oe[0]};
    assign err_contention = r_err;
    assign access_count   = r_count;

endmodule

`default_nettype wire
